// File: rtl/viscosity_pkg.sv
// Shared definitions for the viscosity control path.
// The command width is shared with the sensor DSP stage.
package viscosity_pkg;
  localparam int CTRL_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STOPPING = 2'd2,
    FAULT    = 2'd3
  } pump_state_e;
endpackage

// File: rtl/pump_pwm_driver_if.sv
// Command/status bundle between the control path and the pump PWM driver.
interface pump_pwm_driver_if;
  logic                              en;
  logic [viscosity_pkg::CTRL_W-1:0]  pump_ctrl;
  logic                              fault;
  logic                              clr_fault;
  logic                              pwm_out;
  logic [viscosity_pkg::CTRL_W-1:0]  duty_cur;
  logic                              period_tick;
  logic [1:0]                        state;

  modport master (output en, pump_ctrl, fault, clr_fault,
                  input  pwm_out, duty_cur, period_tick, state);
  modport slave  (input  en, pump_ctrl, fault, clr_fault,
                  output pwm_out, duty_cur, period_tick, state);
endinterface

// File: rtl/pump_pwm_driver_slew_limiter.sv
// Moves the current duty toward the target by at most one step.
// One extra bit of headroom keeps the result from wrapping past 0 or full scale.
module slew_limiter
  import viscosity_pkg::*;
#(
  parameter int W = CTRL_W
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] nxt
);
  logic [W:0] up_gap, dn_gap, up_val, dn_val;

  always_comb begin
    up_gap = {1'b0, tgt} - {1'b0, cur};
    dn_gap = {1'b0, cur} - {1'b0, tgt};
    up_val = {1'b0, cur} + {1'b0, step};
    dn_val = {1'b0, cur} - {1'b0, step};
    nxt    = cur;
    if (tgt >= cur)
      nxt = (up_gap <= {1'b0, step}) ? tgt : (up_val[W] ? {W{1'b1}} : up_val[W-1:0]);
    else
      nxt = (dn_gap <= {1'b0, step}) ? tgt : (dn_val[W] ? {W{1'b0}} : dn_val[W-1:0]);
  end
endmodule

// File: rtl/pump_pwm_driver.sv
// Fixed-frequency PWM drive for the pump power stage with per-period slew
// limiting, enable-driven ramp-down and latched fault shutdown.
module pump_pwm_driver
  import viscosity_pkg::*;
#(
  parameter int PERIOD    = 1000,
  parameter int SLEW_STEP = 16'h0100
) (
  input  logic               clk,
  input  logic               rst,
  pump_pwm_driver_if.slave   bus
);
  localparam logic [CTRL_W-1:0] LAST = CTRL_W'(PERIOD - 1);
  localparam logic [CTRL_W-1:0] STEP = CTRL_W'(SLEW_STEP);

  pump_state_e       st;
  logic [CTRL_W-1:0] cnt, thr, duty, duty_nxt, target, thr_nxt;
  logic              pwm, running, tick;

  assign running = (st == ACTIVE) || (st == STOPPING);
  assign tick    = running && (cnt == LAST);
  assign target  = (st == ACTIVE) ? bus.pump_ctrl : '0;

  slew_limiter #(.W(CTRL_W)) u_slew (
    .cur  (duty),
    .tgt  (target),
    .step (STEP),
    .nxt  (duty_nxt)
  );

  // Threshold tracks the duty it is registered with; full scale yields PERIOD-1.
  assign thr_nxt = CTRL_W'((32'(duty_nxt) * 32'(PERIOD)) >> 16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      cnt  <= '0;
      duty <= '0;
      thr  <= '0;
      pwm  <= 1'b0;
    end else if (bus.fault) begin
      st   <= FAULT;
      cnt  <= '0;
      duty <= '0;
      thr  <= '0;
      pwm  <= 1'b0;
    end else begin
      pwm <= running && (cnt < thr);
      cnt <= (running && !tick) ? cnt + 1'b1 : '0;
      if (tick) begin
        duty <= duty_nxt;
        thr  <= thr_nxt;
      end
      case (st)
        IDLE: begin
          duty <= '0;
          thr  <= '0;
          if (bus.en) st <= ACTIVE;
        end
        ACTIVE:
          if (!bus.en) st <= STOPPING;
        STOPPING:
          if (bus.en)                        st <= ACTIVE;
          else if (tick && duty_nxt == '0)   st <= IDLE;
        FAULT: begin
          duty <= '0;
          thr  <= '0;
          if (bus.clr_fault) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.pwm_out     = pwm;
  assign bus.duty_cur    = duty;
  assign bus.period_tick = tick;
  assign bus.state       = st;
endmodule

// File: tb/tb_pump_pwm_driver.sv
// Bench for pump_pwm_driver: directed scenarios plus random traffic against a
// behavioural model of the period/duty/state rules.
module tb_pump_pwm_driver;
  localparam int PERIOD = 100;
  localparam int STEP   = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pump_pwm_driver_if bus();

  pump_pwm_driver #(.PERIOD(PERIOD), .SLEW_STEP(16'h1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: state as 0..3, counter as cycles since start mod PERIOD,
  // threshold derived from the applied duty on the fly.
  int m_st, m_cnt, m_duty;
  bit m_pwm;

  function automatic int toward(int cur, int tgt);
    if (tgt >= cur) return (tgt - cur <= STEP) ? tgt : cur + STEP;
    return (cur - tgt <= STEP) ? tgt : cur - STEP;
  endfunction

  function automatic bit m_run();
    return (m_st == 1) || (m_st == 2);
  endfunction

  function automatic bit m_tick();
    return m_run() && (m_cnt == PERIOD - 1);
  endfunction

  function automatic int m_next_duty();
    int tgt;
    tgt = (m_st == 1) ? int'(bus.pump_ctrl) : 0;
    return m_tick() ? toward(m_duty, tgt) : m_duty;
  endfunction

  function automatic int m_next_state();
    if (bus.fault) return 3;
    case (m_st)
      0: return bus.en ? 1 : 0;
      1: return bus.en ? 1 : 2;
      2: if (bus.en) return 1;
         else return (m_tick() && m_next_duty() == 0) ? 0 : 2;
      default: return bus.clr_fault ? 0 : 3;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st   <= 0;
      m_cnt  <= 0;
      m_duty <= 0;
      m_pwm  <= 1'b0;
    end else begin
      m_pwm  <= !bus.fault && m_run() && (m_cnt < (m_duty * PERIOD) / 65536);
      m_cnt  <= (!bus.fault && m_run()) ? (m_cnt + 1) % PERIOD : 0;
      m_duty <= (bus.fault || !m_run()) ? 0 : m_next_duty();
      m_st   <= m_next_state();
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (bus.pwm_out !== m_pwm || int'(bus.duty_cur) != m_duty ||
          bus.period_tick !== m_tick() || int'(bus.state) != m_st) begin
        errors++;
        $display("FAIL model t=%0t got pwm=%0b duty=%h tick=%0b st=%0d want pwm=%0b duty=%h tick=%0b st=%0d",
                 $time, bus.pwm_out, bus.duty_cur, bus.period_tick, bus.state,
                 m_pwm, m_duty[15:0], m_tick(), m_st);
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Returns at the negedge just after a tick, when the new duty is visible.
  task automatic wait_tick();
    int n = 0;
    while (!bus.period_tick && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.period_tick) begin
      errors++;
      checks++;
      $display("FAIL tick_timeout got=none want=tick t=%0t", $time);
    end
    @(negedge clk);
  endtask

  task automatic count_high(input int cycles, output int h);
    h = 0;
    repeat (cycles) begin
      @(negedge clk);
      h += int'(bus.pwm_out);
    end
  endtask

  task automatic ramp_up(input int from_k, input int to_k, input string name);
    for (int k = from_k; k <= to_k; k++) begin
      wait_tick();
      chk(name, int'(bus.duty_cur), k * STEP);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    bus.en = 1'b0; bus.pump_ctrl = 16'h8000; bus.fault = 1'b0; bus.clr_fault = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(bus.pwm_out), 0);
    chk("rst_duty", int'(bus.duty_cur), 0);
    chk("rst_tick", int'(bus.period_tick), 0);
    chk("rst_state", int'(bus.state), 0);
    rst = 1'b0;

    // Idle with a command present: nothing must move.
    count_high(1000, h);
    chk("idle_high", h, 0);
    chk("idle_state", int'(bus.state), 0);
    chk("idle_duty", int'(bus.duty_cur), 0);

    // Soft start to half scale.
    bus.en = 1'b1;
    @(negedge clk);
    chk("start_state", int'(bus.state), 1);
    ramp_up(1, 8, "ramp_duty");
    chk("model_duty_pin", m_duty, 32'h8000);
    count_high(PERIOD, h);
    chk("half_high", h, 50);

    // Near full scale: saturate at 0xFFFF.
    bus.pump_ctrl = 16'hF800;
    for (int k = 0; k < 8; k++) wait_tick();
    chk("duty_f800", int'(bus.duty_cur), 32'hF800);
    bus.pump_ctrl = 16'hFFFF;
    wait_tick();
    chk("duty_ffff", int'(bus.duty_cur), 32'hFFFF);
    count_high(PERIOD, h);
    chk("full_high", h, 99);

    bus.pump_ctrl = 16'h8000;
    for (int k = 0; k < 12 && bus.duty_cur != 16'h8000; k++) wait_tick();
    chk("back_8000", int'(bus.duty_cur), 32'h8000);

    // Ramp-down, resume, then stop to idle.
    bus.en = 1'b0;
    @(negedge clk);
    chk("stop_state", int'(bus.state), 2);
    for (int k = 7; k >= 3; k--) begin
      wait_tick();
      chk("down_duty", int'(bus.duty_cur), k * STEP);
    end
    bus.en = 1'b1;
    @(negedge clk);
    chk("resume_state", int'(bus.state), 1);
    wait_tick();
    chk("resume_duty", int'(bus.duty_cur), 32'h4000);
    bus.en = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      wait_tick();
      chk("down2_duty", int'(bus.duty_cur), k * STEP);
    end
    chk("stopped_state", int'(bus.state), 0);

    // Fault mid-pulse and recovery.
    bus.en = 1'b1;
    ramp_up(1, 8, "ramp2_duty");
    repeat (20) @(negedge clk);
    chk("pulse_hi", int'(bus.pwm_out), 1);
    bus.fault = 1'b1;
    @(negedge clk);
    chk("fault_pwm", int'(bus.pwm_out), 0);
    chk("fault_state", int'(bus.state), 3);
    chk("fault_duty", int'(bus.duty_cur), 0);
    bus.clr_fault = 1'b1;
    @(negedge clk);
    bus.clr_fault = 1'b0;
    chk("fault_hold", int'(bus.state), 3);
    bus.fault = 1'b0;
    @(negedge clk);
    chk("fault_latched", int'(bus.state), 3);
    bus.clr_fault = 1'b1;
    @(negedge clk);
    bus.clr_fault = 1'b0;
    chk("clr_idle", int'(bus.state), 0);
    @(negedge clk);
    chk("reenter_state", int'(bus.state), 1);
    chk("reenter_duty", int'(bus.duty_cur), 0);
    ramp_up(1, 8, "soft_duty");

    // Asynchronous reset mid-pulse.
    repeat (20) @(negedge clk);
    chk("pulse_hi2", int'(bus.pwm_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pwm", int'(bus.pwm_out), 0);
    chk("async_duty", int'(bus.duty_cur), 0);
    chk("async_state", int'(bus.state), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", int'(bus.state), 1);
    ramp_up(1, 8, "post_rst_duty");
    count_high(PERIOD, h);
    chk("post_rst_high", h, 50);

    // Random traffic against the model.
    repeat (4000) begin
      @(negedge clk);
      bus.pump_ctrl = 16'($urandom);
      if ($urandom_range(0, 399) == 0) bus.en = ~bus.en;
      bus.fault     = ($urandom_range(0, 799) == 0);
      bus.clr_fault = ($urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pump_pwm_driver.md
# pump_pwm_driver

Back-end actuator stage of the viscosity control path. Consumes the 16-bit `pump_ctrl` command produced by the sensor DSP stage and turns it into a fixed-frequency PWM drive for the pump power stage. Enforces a per-period slew limit (soft start/stop), an enable-driven ramp-down, and a latched fault shutdown.

## Interface
- `PERIOD`, 1000: PWM period in `clk` cycles; legal range 2..65535.
- `SLEW_STEP`, 16'h0100: maximum change of `duty_cur` per PWM period; legal range 1..65535.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: run request, level-sensitive.
- `pump_ctrl`  in  16: target duty, unsigned Q0.16 (0x0000 = off, 0xFFFF = maximum).
- `fault`  in  1: power-stage fault, active-high, synchronous to `clk`.
- `clr_fault`  in  1: single-cycle pulse that clears a latched fault.
- `pwm_out`  out  1: pump drive, registered.
- `duty_cur`  out  16: duty currently applied.
- `period_tick`  out  1: one-cycle pulse on the last cycle of each PWM period.
- `state`  out  2: FSM state (IDLE=0, ACTIVE=1, STOPPING=2, FAULT=3).

## Operation
- Period counter `cnt` runs 0..PERIOD-1 and wraps. It is held at 0 in IDLE and FAULT. `period_tick` = (cnt == PERIOD-1) while the counter runs.
- Threshold `thr` = (duty × PERIOD) >> 16, computed with a 32-bit product. It is registered together with `duty_cur`. Consequence: duty 0xFFFF gives PERIOD-1 high cycles; 100 % duty is not reachable by design.
- `pwm_out` <= running && (cnt < thr). It is high for exactly `thr` cycles per period, starting one cycle after cnt==0.
- Slew update happens only on `period_tick`, toward the target T:
  - In ACTIVE, T = `pump_ctrl` sampled on that cycle.
  - In STOPPING, T = 0.
  - If |T − duty_cur| ≤ SLEW_STEP, duty_cur := T. Otherwise duty_cur moves by SLEW_STEP toward T.
  - Use 17-bit arithmetic so the result never wraps past 0 or 0xFFFF.
- `pump_ctrl` changes between ticks are ignored.

FSM:
- IDLE: duty_cur = 0, pwm_out = 0.
  - en && !fault → ACTIVE; the counter starts at 0 on the next cycle.
- ACTIVE: ramps toward `pump_ctrl`.
  - !en → STOPPING.
- STOPPING: ramps down.
  - en → ACTIVE; ramping continues from the current duty.
  - duty_cur reaches 0 on a tick → IDLE.
- Any state, fault = 1 → FAULT on the next edge. Fault has priority over every other transition.
- FAULT: pwm_out = 0, duty_cur = 0, thr = 0, cnt = 0.
  - clr_fault && !fault → IDLE.
  - clr_fault while fault = 1 is ignored.
- If `en` is high when FAULT exits to IDLE, the block re-enters ACTIVE on the following cycle and soft-starts from duty 0.

## Timing
- Reset values: pwm_out = 0, duty_cur = 0, period_tick = 0, state = IDLE; cnt = 0 and thr = 0.
- Reset asserted mid-ramp or mid-pulse drops pwm_out to 0 asynchronously.
- Command latency: a `pump_ctrl` sampled on a tick takes effect from the first cycle of the next period.
- Full-scale ramp from 0 takes ceil(target / SLEW_STEP) periods.
- Fault shutdown: pwm_out is 0 on the first edge after `fault` is seen high; maximum 1 clk of extra drive.
- en → ACTIVE: 1 cycle. First PWM high cycle follows the first tick, because duty_cur is 0 until then.

## Structure
- Shared package `viscosity_pkg` holds:
  - the state encoding constants (IDLE/ACTIVE/STOPPING/FAULT);
  - the `pump_ctrl` width constant (16), shared with the DSP stage.
- One sub-module is natural: `slew_limiter`. It is combinational: current, target and step in; next duty out, saturating.
- FSM, period counter, threshold multiply and output register stay in the top module.

## Test plan
All scenarios use PERIOD=100 and SLEW_STEP=0x1000.
1. Reset, en=0, pump_ctrl=0x8000 → pwm_out=0, duty_cur=0, state=0 for 1000 cycles.
2. en=1, pump_ctrl=0x8000 → duty_cur=0x1000, 0x2000, … 0x8000 on successive ticks (8 periods). Then thr=50: pwm_out high exactly 50 of every 100 cycles.
3. From duty 0xF800, pump_ctrl=0xFFFF → next duty 0xFFFF, with no wrap to 0x0800. pwm_out high 99 of every 100 cycles.
4. At duty 0x8000, drop en → state=STOPPING, duty falls by 0x1000 per tick, IDLE on the tick reaching 0. Re-asserting en at duty 0x3000 resumes ramping up from 0x3000.
5. Fault mid-pulse at duty 0x8000 → pwm_out=0 next edge, state=FAULT, duty_cur=0.
   - clr_fault with fault=1 → stays in FAULT.
   - fault=0 then clr_fault → IDLE; with en=1, soft-start from 0.
6. Assert rst at cnt=20 while pwm_out=1 → pwm_out=0 immediately. After release, behaviour is identical to scenario 2.
